// File: rtl/ehl_gpio_debounce.sv
// ehl_gpio_debounce
// -----------------------------------------------------------------------------
// Per-pin input conditioner sitting in front of the GPIO core's gpio_in port.
// Raw pad levels are synchronised, then each pin is passed through a stability
// filter clocked by a shared prescaled tick. A new level has to be seen on
// thresh+1 consecutive ticks before pin_out follows it, and any return to the
// current pin_out level restarts the count. Everything runs on the ungated
// clock, so conditioning continues while the bus clock is gated.
//
// Ports
//   clk_ug   in   1        ungated clock
//   reset_n  in   1        asynchronous reset, active-low
//   ena      in   1        global debounce enable (bypassed pins ignore it)
//   presc    in   PRESC_W  tick period minus 1, in clk_ug cycles
//   thresh   in   CNT_W    required stable ticks minus 1
//   bypass   in   WIDTH    per-pin filter bypass (pin_out follows synced pad)
//   pin_in   in   WIDTH    raw asynchronous pad inputs
//   pin_out  out  WIDTH    debounced level, registered
//   change   out  WIDTH    one-cycle pulse, one cycle after a pin_out toggle
//   busy     out  WIDTH    transition pending qualification
//
// Build option
//   GPIO_DEBOUNCE_BUSY_EN  when defined, busy is a registered per-pin flag;
//                          when undefined, busy is tied to zero and costs no
//                          flops.
//
// Parameters
//   WIDTH       number of pins
//   CNT_W       width of the per-pin stability counter and of thresh
//   PRESC_W     width of the prescaler counter and of presc
//   SYNC_STAGE  synchroniser depth, 2..4
// -----------------------------------------------------------------------------
module ehl_gpio_debounce #(
    parameter int WIDTH      = 32,
    parameter int CNT_W      = 8,
    parameter int PRESC_W    = 16,
    parameter int SYNC_STAGE = 2
) (
    input  logic               clk_ug,
    input  logic               reset_n,
    input  logic               ena,
    input  logic [PRESC_W-1:0] presc,
    input  logic [CNT_W-1:0]   thresh,
    input  logic [WIDTH-1:0]   bypass,
    input  logic [WIDTH-1:0]   pin_in,
    output logic [WIDTH-1:0]   pin_out,
    output logic [WIDTH-1:0]   change,
    output logic [WIDTH-1:0]   busy
);

    localparam logic [PRESC_W-1:0] PRESC_ONE = 1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = 1;

    // -------------------------------------------------------------------------
    // Synchroniser: stage 0 samples the pad, the last stage is the usable level
    // -------------------------------------------------------------------------
    logic [SYNC_STAGE-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                 s;

    always_ff @(posedge clk_ug or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGE-2:0], pin_in};
        end
    end

    assign s = sync_q[SYNC_STAGE-1];

    // -------------------------------------------------------------------------
    // Shared prescaler. The >= compare means lowering presc below the running
    // count produces a tick on the next cycle instead of a long wrap.
    // -------------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;

    assign tick = ena && (presc_cnt >= presc);

    always_ff @(posedge clk_ug or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt <= '0;
        end else if (!ena || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PRESC_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Per-pin stability filter
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] pin_out_q;
    logic [WIDTH-1:0] pin_out_d;

    always_comb begin
        cnt_d     = cnt_q;
        pin_out_d = pin_out_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (bypass[i]) begin
                pin_out_d[i] = s[i];
                cnt_d[i]     = '0;
            end else if (!ena || (s[i] == pin_out_q[i])) begin
                // disabled, or input agrees with output: nothing to qualify
                cnt_d[i] = '0;
            end else if (tick) begin
                // >= so a thresh lowered below the running count commits now
                if (cnt_q[i] >= thresh) begin
                    pin_out_d[i] = s[i];
                    cnt_d[i]     = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_ug or negedge reset_n) begin
        if (!reset_n) begin
            pin_out_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pin_out_q <= pin_out_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pin_out = pin_out_q;

    // -------------------------------------------------------------------------
    // Change pulse: registered edge detect of pin_out, so the pulse lands one
    // cycle after the pin_out edge. Both flops reset to 0, so reset release
    // never produces a pulse.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] pin_out_dly;
    logic [WIDTH-1:0] change_q;

    always_ff @(posedge clk_ug or negedge reset_n) begin
        if (!reset_n) begin
            pin_out_dly <= '0;
            change_q    <= '0;
        end else begin
            pin_out_dly <= pin_out_q;
            change_q    <= pin_out_q ^ pin_out_dly;
        end
    end

    assign change = change_q;

    // -------------------------------------------------------------------------
    // Pending-transition flag
    // -------------------------------------------------------------------------
`ifdef GPIO_DEBOUNCE_BUSY_EN
    logic [WIDTH-1:0] busy_q;

    always_ff @(posedge clk_ug or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= (s ^ pin_out_q) & ~bypass & {WIDTH{ena}};
        end
    end

    assign busy = busy_q;
`else
    assign busy = '0;
`endif

endmodule

// File: tb/tb_ehl_gpio_debounce.sv
// Directed bench for ehl_gpio_debounce (default parameters: 32 pins,
// 2-stage synchroniser). Inputs change and outputs are sampled on the falling
// edge; "step k" means k rising edges after the reset-release falling edge.
module tb_ehl_gpio_debounce;

    logic        clk_ug = 1'b0;
    logic        reset_n;
    logic        ena;
    logic [15:0] presc;
    logic [7:0]  thresh;
    logic [31:0] bypass;
    logic [31:0] pin_in;
    logic [31:0] pin_out;
    logic [31:0] change;
    logic [31:0] busy;

`ifdef GPIO_DEBOUNCE_BUSY_EN
    localparam logic BUSY_ON = 1'b1;
`else
    localparam logic BUSY_ON = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    ehl_gpio_debounce dut (
        .clk_ug  (clk_ug),
        .reset_n (reset_n),
        .ena     (ena),
        .presc   (presc),
        .thresh  (thresh),
        .bypass  (bypass),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .change  (change),
        .busy    (busy)
    );

    always #5 clk_ug = ~clk_ug;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_ug);
            @(negedge clk_ug);
        end
    endtask

    function automatic logic [31:0] busy_exp(input logic [31:0] v);
        return BUSY_ON ? v : 32'h0;
    endfunction

    // Reset with the given configuration applied, check the reset state, then
    // release on a falling edge.
    task automatic start(input logic e, input logic [15:0] p, input logic [7:0] t,
                         input logic [31:0] byp, input logic [31:0] pin);
        @(negedge clk_ug);
        reset_n = 1'b0;
        ena     = e;
        presc   = p;
        thresh  = t;
        bypass  = byp;
        pin_in  = pin;
        #1;
        check("rst_pin_out", pin_out, 32'h0);
        check("rst_change", change, 32'h0);
        step(2);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] pin;
        logic [31:0] exp_out;
        logic [31:0] exp_chg;
    } vec_t;

    vec_t vecs [12];
    logic [31:0] acc;

    initial begin
        // bypass path: pin_out(j) = pin(j-2), change(j) = out(j-1) ^ out(j-2)
        vecs[0]  = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
        vecs[1]  = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
        vecs[2]  = '{32'h0000_00F0, 32'h0000_0001, 32'h0000_0000};
        vecs[3]  = '{32'h0000_00F0, 32'h0000_0001, 32'h0000_0001};
        vecs[4]  = '{32'hFFFF_0000, 32'h0000_00F0, 32'h0000_0000};
        vecs[5]  = '{32'hFFFF_0000, 32'h0000_00F0, 32'h0000_00F1};
        vecs[6]  = '{32'hFFFF_0000, 32'hFFFF_0000, 32'h0000_0000};
        vecs[7]  = '{32'h0000_0000, 32'hFFFF_0000, 32'hFFFF_00F0};
        vecs[8]  = '{32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000};
        vecs[9]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_0000};
        vecs[11] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

        reset_n = 1'b0;
        ena     = 1'b0;
        presc   = '0;
        thresh  = '0;
        bypass  = '0;
        pin_in  = '0;

        // ---- bypass table (ena low: bypassed pins still follow) ----
        start(1'b0, 16'd0, 8'd0, 32'hFFFF_FFFF, 32'h0);
        for (int j = 0; j < 12; j++) begin
            pin_in = vecs[j].pin;
            step(1);
            check($sformatf("byp_out[%0d]", j), pin_out, vecs[j].exp_out);
            check($sformatf("byp_chg[%0d]", j), change, vecs[j].exp_chg);
        end

        // ---- steady high on pin 5, presc=3 thresh=2: ticks at 4, 8, 12 ----
        start(1'b1, 16'd3, 8'd2, 32'h0, 32'h0000_0020);
        step(6);
        check("a_busy_pending", busy, busy_exp(32'h0000_0020));
        step(5);
        check("a_out_step11", pin_out, 32'h0);
        step(1);
        check("a_out_step12", pin_out, 32'h0000_0020);
        check("a_chg_step12", change, 32'h0);
        step(1);
        check("a_chg_step13", change, 32'h0000_0020);
        check("a_busy_clear", busy, 32'h0);
        step(1);
        check("a_chg_step14", change, 32'h0);

        // ---- 6-cycle glitch on pin 5 never qualifies ----
        start(1'b1, 16'd3, 8'd2, 32'h0, 32'h0000_0020);
        step(5);
        check("b_busy_pending", busy, busy_exp(32'h0000_0020));
        step(1);
        pin_in = 32'h0;
        acc = 32'h0;
        for (int k = 7; k <= 26; k++) begin
            step(1);
            if (k == 10) check("b_busy_clear", busy, 32'h0);
            acc = acc | pin_out | change;
        end
        check("b_glitch_quiet", acc, 32'h0);

        // ---- presc=0 thresh=0: all pins move together ----
        start(1'b1, 16'd0, 8'd0, 32'h0, 32'h0);
        pin_in = 32'hFFFF_FFFF;
        step(2);
        check("c_out_step2", pin_out, 32'h0);
        step(1);
        check("c_out_step3", pin_out, 32'hFFFF_FFFF);
        step(1);
        check("c_chg_step4", change, 32'hFFFF_FFFF);
        step(1);
        check("c_chg_step5", change, 32'h0);
        pin_in = 32'h0;
        step(2);
        check("c_out_fall_hold", pin_out, 32'hFFFF_FFFF);
        step(1);
        check("c_out_fall", pin_out, 32'h0);
        step(1);
        check("c_chg_fall", change, 32'hFFFF_FFFF);

        // ---- drop ena with cnt=1 of thresh=4; five fresh ticks needed ----
        start(1'b1, 16'd3, 8'd4, 32'h0, 32'h0000_0020);
        step(5);
        ena = 1'b0;
        step(4);
        check("d_out_disabled", pin_out, 32'h0);
        check("d_busy_disabled", busy, 32'h0);
        ena = 1'b1;
        step(19);
        check("d_out_step28", pin_out, 32'h0);
        step(1);
        check("d_out_step29", pin_out, 32'h0000_0020);
        step(1);
        check("d_chg_step30", change, 32'h0000_0020);

        // ---- reset during qualification with pads high ----
        start(1'b1, 16'd0, 8'd0, 32'h0, 32'hFFFF_FFFF);
        step(3);
        check("e_out_high", pin_out, 32'hFFFF_FFFF);
        presc  = 16'd3;
        thresh = 8'd2;
        pin_in = 32'hFFFF_FFF0;
        step(3);
        reset_n = 1'b0;
        pin_in  = 32'hFFFF_FFFF;
        #1;
        check("e_rst_out", pin_out, 32'h0);
        check("e_rst_chg", change, 32'h0);
        check("e_rst_busy", busy, 32'h0);
        step(2);
        reset_n = 1'b1;
        step(1);
        check("e_no_rel_pulse", change, 32'h0);
        step(10);
        check("e_out_step11", pin_out, 32'h0);
        step(1);
        check("e_out_step12", pin_out, 32'hFFFF_FFFF);
        step(1);
        check("e_chg_step13", change, 32'hFFFF_FFFF);
        step(1);
        check("e_chg_step14", change, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
